// File: rtl/seg_p2s_tx_if.sv
// ----------------------------------------------------------------------------
// seg_p2s_tx_if
//   Bundles the frame handshake and the serial pin bus of the segment
//   parallel-to-serial transmitter.
//
//   Signals:
//     start     frame request (master -> transmitter)
//     par_data  DATA_BITS segment frame, bit 0 shifted first
//     busy      high while a frame is being shifted
//     done      one-cycle pulse after the last bit has been clocked
//     s_clk     serial clock to the 74HC164 chain
//     s_dat     serial data
//     s_clr_n   chain clear, active-low
//     s_pen     display enable, low while shifting
//
//   Modports:
//     master  the frame source (segment encoder side / testbench)
//     slave   the transmitter itself
// ----------------------------------------------------------------------------
interface seg_p2s_tx_if #(
    parameter int DATA_BITS = 64
);
    logic                 start;
    logic [DATA_BITS-1:0] par_data;
    logic                 busy;
    logic                 done;
    logic                 s_clk;
    logic                 s_dat;
    logic                 s_clr_n;
    logic                 s_pen;

    modport master (
        output start, par_data,
        input  busy, done, s_clk, s_dat, s_clr_n, s_pen
    );

    modport slave (
        input  start, par_data,
        output busy, done, s_clk, s_dat, s_clr_n, s_pen
    );
endinterface

// File: rtl/seg_p2s_tx.sv
// ----------------------------------------------------------------------------
// seg_p2s_tx
//   Serial transmitter for the segment pattern produced by the hex-to-segment
//   encoder. A frame is captured on a start strobe and shifted LSB-first into
//   the board's external 74HC164 chain with a divided serial clock; the
//   display is blanked while shifting and enabled once the frame is complete.
//
//   Parameters:
//     DATA_BITS  frame length in bits (= serial clocks per frame)
//     CLK_DIV    clk cycles per s_clk half-period, >= 1
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous reset, active-high
//     bus   seg_p2s_tx_if.slave: start, par_data in; busy, done, s_clk,
//           s_dat, s_clr_n, s_pen out
//
//   Optional feature (macro SEG_P2S_AUTO_REFRESH_EN):
//     When defined, a shadow copy of the last transmitted frame is kept and
//     any difference between par_data and the shadow starts a frame while
//     idle, exactly as start would. When undefined, only start sends frames.
// ----------------------------------------------------------------------------
module seg_p2s_tx #(
    parameter int DATA_BITS = 64,
    parameter int CLK_DIV   = 2
) (
    input logic         clk,
    input logic         rst,
    seg_p2s_tx_if.slave bus
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        FIN
    } state_t;

    state_t state;
    state_t state_d;

    logic [DATA_BITS-1:0] shreg;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic                 last_bit;
    logic                 frame_sent;
    logic                 clr_n_q;

    logic trigger;
    logic load;
    logic phase_end;

    assign phase_end = (div_cnt == DIV_LAST);

`ifdef SEG_P2S_AUTO_REFRESH_EN
    // Shadow of the last loaded frame; a difference against the live input
    // behaves like a start request while idle.
    logic [DATA_BITS-1:0] shadow;

    assign trigger = bus.start || (bus.par_data != shadow);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= bus.par_data;
        end
    end
`else
    assign trigger = bus.start;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: each serial bit spends CLK_DIV cycles low and
    // CLK_DIV cycles high; the last high phase leads into the single FIN cycle.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    load    = 1'b1;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    state_d = (bit_cnt == BIT_LAST) ? FIN : LOW;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. While shifting, s_dat follows the bit at the bottom of
    // the shift register; outside a frame it holds the last bit actually sent.
    always_comb begin
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.s_clk   = 1'b0;
        bus.s_dat   = last_bit;
        bus.s_pen   = 1'b0;
        bus.s_clr_n = clr_n_q;
        case (state)
            IDLE: begin
                bus.s_pen = frame_sent;
            end
            LOW: begin
                bus.busy  = 1'b1;
                bus.s_dat = shreg[0];
            end
            HIGH: begin
                bus.busy  = 1'b1;
                bus.s_clk = 1'b1;
                bus.s_dat = shreg[0];
            end
            FIN: begin
                bus.done  = 1'b1;
                bus.s_pen = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    // Datapath: frame capture, divider and bit counters, and the shift
    // register. The bit is latched into last_bit as its high phase ends so
    // the idle line keeps showing it after the register has moved on.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            last_bit   <= 1'b0;
            frame_sent <= 1'b0;
            clr_n_q    <= 1'b0;
        end else begin
            clr_n_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg   <= bus.par_data;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        div_cnt  <= '0;
                        last_bit <= shreg[0];
                        shreg    <= shreg >> 1;
                        if (bit_cnt != BIT_LAST) begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                FIN: begin
                    frame_sent <= 1'b1;
                end
                default: begin
                    div_cnt <= '0;
                end
            endcase
        end
    end

endmodule
